// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: op codes, access sizes, FSM states.
package load_store_unit_pkg;

  localparam logic [1:0] MEM_DISABLE   = 2'b00;
  localparam logic [1:0] MEM_READ_SEXT = 2'b01;
  localparam logic [1:0] MEM_READ_ZEXT = 2'b10;
  localparam logic [1:0] MEM_WRITE     = 2'b11;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  localparam int LSU_TIMEOUT_DEFAULT = 8;

  typedef enum logic {
    ST_IDLE,
    ST_RD_WAIT
  } lsu_state_e;

  // Byte offset within the word after masking the address to the access size.
  function automatic logic [1:0] eff_offset(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return off;
      SZ_HALF: return {off[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half/word lane of a RAM read word and sign- or
// zero-extends it to 32 bits. Purely combinational.
module lsu_load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] mem_dout,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (off)
      2'd0:    byte_lane = mem_dout[7:0];
      2'd1:    byte_lane = mem_dout[15:8];
      2'd2:    byte_lane = mem_dout[23:16];
      default: byte_lane = mem_dout[31:24];
    endcase
    half_lane = off[1] ? mem_dout[31:16] : mem_dout[15:0];

    case (size)
      SZ_BYTE: data = {{24{sign & byte_lane[7]}}, byte_lane};
      SZ_HALF: data = {{16{sign & half_lane[15]}}, half_lane};
      default: data = mem_dout;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit driving the data-memory port of the SRAM wrapper.
// Optional: define LSU_MISALIGN_TRAP_EN to fault on misaligned half/word accesses
// instead of masking the low address bits.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic [3:0]  mem_web,
  output logic        mem_en,
  input  logic [31:0] mem_dout,
  input  logic        mem_read_valid,
  input  logic        mem_not_ready,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        store_done,
  output logic        fault
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  function automatic logic [3:0] store_web(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] w);
    case (size)
      SZ_BYTE: return {4{w[7:0]}};
      SZ_HALF: return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        ld_size_q, ld_size_d;
  logic              ld_sign_q, ld_sign_d;
  logic [1:0]        ld_off_q, ld_off_d;
  logic [4:0]        ld_rd_q, ld_rd_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_data_q, resp_data_d;
  logic [4:0]        resp_rd_q, resp_rd_d;
  logic              store_done_q, store_done_d;
  logic              fault_q, fault_d;

  logic              is_load, is_store, size_ok, trap, accept, do_issue;
  logic [1:0]        eff_off;
  logic [31:0]       load_data;

  lsu_load_align u_align (
    .mem_dout (mem_dout),
    .off      (ld_off_q),
    .size     (ld_size_q),
    .sign     (ld_sign_q),
    .data     (load_data)
  );

  // Request decode and combinational issue onto the RAM port.
  always_comb begin
    is_store = (req_op == MEM_WRITE);
    is_load  = (req_op == MEM_READ_SEXT) || (req_op == MEM_READ_ZEXT);
    size_ok  = (req_size != SZ_ILLEGAL);
    eff_off  = eff_offset(req_size, req_addr[1:0]);
`ifdef LSU_MISALIGN_TRAP_EN
    trap = (is_load || is_store) && size_ok &&
           (((req_size == SZ_HALF) && req_addr[0]) ||
            ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00)));
`else
    trap = 1'b0;
`endif
    req_ready = reset && (state_q == ST_IDLE) && !mem_not_ready;
    accept    = req_valid && req_ready;
    do_issue  = accept && (is_load || is_store) && size_ok && !trap;
    mem_en    = do_issue;
    mem_addr  = {req_addr[31:2], 2'b00};
    mem_web   = (do_issue && is_store) ? store_web(req_size, eff_off) : 4'b0000;
    mem_din   = lane_replicate(req_size, req_wdata);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ld_size_d    = ld_size_q;
    ld_sign_d    = ld_sign_q;
    ld_off_d     = ld_off_q;
    ld_rd_d      = ld_rd_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_rd_d    = resp_rd_q;
    store_done_d = 1'b0;
    fault_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // MEM_DISABLE is swallowed here: accepted, but nothing happens.
        if (accept && (is_load || is_store)) begin
          if (!size_ok || trap) begin
            fault_d   = 1'b1;
            resp_rd_d = req_rd;
          end else if (is_store) begin
            store_done_d = 1'b1;
          end else begin
            state_d   = ST_RD_WAIT;
            cnt_d     = '0;
            ld_size_d = req_size;
            ld_sign_d = (req_op == MEM_READ_SEXT);
            ld_off_d  = eff_off;
            ld_rd_d   = req_rd;
          end
        end
      end
      ST_RD_WAIT: begin
        if (mem_read_valid) begin
          resp_valid_d = 1'b1;
          resp_data_d  = load_data;
          resp_rd_d    = ld_rd_q;
          state_d      = ST_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // This cycle is the TIMEOUT_CYCLES-th spent waiting.
          fault_d   = 1'b1;
          resp_rd_d = ld_rd_q;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and response registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_rd_q    <= '0;
      store_done_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_rd_q    <= resp_rd_d;
      store_done_q <= store_done_d;
      fault_q      <= fault_d;
    end
  end

  // Captured load attributes are only meaningful in RD_WAIT, so they need no reset.
  always_ff @(posedge clk) begin
    ld_size_q <= ld_size_d;
    ld_sign_q <= ld_sign_d;
    ld_off_q  <= ld_off_d;
    ld_rd_q   <= ld_rd_d;
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_rd    = resp_rd_q;
  assign store_done = store_done_q;
  assign fault      = fault_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory port (port B) of the dual-port SRAM wrapper.
- Accepts one load/store request at a time from the execute stage and drives the word-wide, byte-enabled SRAM port.
- Collects the registered read response and returns aligned, sign- or zero-extended load data to writeback.
- Sits between the EX/MEM pipeline register and the RAM port-B pins.

Parameters:
- MEM_DISABLE, 2'b00, op code: no memory access
- MEM_READ_SEXT, 2'b01, op code: load, sign-extend
- MEM_READ_ZEXT, 2'b10, op code: load, zero-extend
- MEM_WRITE, 2'b11, op code: store
- TIMEOUT_CYCLES, 8, maximum cycles to wait for mem_read_valid before a fault response

Ports:
- clk, input, 1: clock
- reset, input, 1: synchronous, active-low reset (0 = reset)
- req_valid, input, 1: request present
- req_ready, output, 1: LSU can accept a request this cycle
- req_op, input, 2: MEM_* op code
- req_size, input, 2: 00 byte, 01 half, 10 word, 11 illegal
- req_addr, input, 32: byte address
- req_wdata, input, 32: store data (LSBs significant)
- req_rd, input, 5: destination register tag
- mem_addr, output, 32: byte address to RAM, word-aligned (low two bits are 0)
- mem_din, output, 32: store data, lane-replicated
- mem_web, output, 4: per-byte write enables
- mem_en, output, 1: port enable
- mem_dout, input, 32: RAM read data
- mem_read_valid, input, 1: RAM read-data valid
- mem_not_ready, input, 1: RAM busy; do not issue
- resp_valid, output, 1: one-cycle load result strobe
- resp_data, output, 32: extended load data
- resp_rd, output, 5: tag of the returning load
- store_done, output, 1: one-cycle pulse, the cycle after a store issues
- fault, output, 1: one-cycle pulse for illegal size, timeout, or (optional) misalignment

Behaviour:
- Reset values (reset=0 at a clk edge):
  - FSM goes to IDLE; timeout counter is 0.
  - resp_valid=0, resp_data=0, resp_rd=0, store_done=0, fault=0.
  - Combinational outputs mem_en=0, mem_web=0, req_ready=0 while reset is low.
- FSM states: IDLE and RD_WAIT.
- IDLE:
  - req_ready = !mem_not_ready.
  - A request is accepted when req_valid && req_ready.
  - MEM_DISABLE is accepted, causes no memory access and produces no response.
- Issue on the accept cycle (combinational drive; the RAM registers it):
  - mem_en=1, mem_addr={req_addr[31:2],2'b00}.
- Store issue:
  - mem_web: byte → 4'b0001<<off; half → 4'b0011<<off; word → 4'b1111, where off=req_addr[1:0].
  - mem_din: byte replicated x4; half replicated x2; word unchanged.
  - store_done pulses at cycle +1. FSM stays in IDLE, so back-to-back stores are allowed.
- Load issue:
  - mem_web=0.
  - Capture size, sign, off and rd into registers; go to RD_WAIT.
- RD_WAIT:
  - req_ready=0; mem_not_ready is ignored.
  - When mem_read_valid=1:
    - Select the lane: byte mem_dout[8*off+:8], half mem_dout[16*off[1]+:16], word whole.
    - Extend per the captured sign and register the result: resp_valid=1 at the next edge.
    - Return to IDLE.
  - Nominal load latency: accept at cycle N, RAM valid at N+1, resp_valid at N+2.
  - Next request is accepted at N+2 at the earliest.
- Timeout:
  - The counter increments each cycle in RD_WAIT.
  - Reaching TIMEOUT_CYCLES without mem_read_valid pulses fault with resp_rd set, keeps resp_valid=0, and returns to IDLE.
- Illegal size (req_size=11): accepted, no memory access, fault pulses at +1.
- Half-word with off=1 or 3 when the option is absent: treated as off&2'b10.
- Reset mid-operation: an outstanding load is discarded with no response; a late mem_read_valid in IDLE is ignored.
- mem_read_valid in IDLE is always ignored.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - half with addr[0]=1, or word with addr[1:0]!=0, is accepted but not issued (mem_en=0).
  - fault pulses at +1 with resp_rd set.
- Undefined:
  - The low address bits are masked to the access size (half: addr[0] cleared; word: addr[1:0] cleared).
  - The access proceeds normally.

Decomposition:
- Shared package holds:
  - MEM_* op codes
  - size codes SZ_BYTE / SZ_HALF / SZ_WORD
  - FSM state enum
- Natural sub-module: lsu_load_align, purely combinational (mem_dout, off, size, sign) → 32-bit extended data. The FSM module instantiates it.

Test Plan:
- Word store 0xDEADBEEF at 0x100, then word load from 0x100: web=4'b1111 at issue; resp_data=0xDEADBEEF at N+2; store_done pulses once.
- Byte store 0x80 at 0x103: web=4'b1000, din=0x80808080. Then SEXT byte load from 0x103 → 0xFFFFFF80; ZEXT byte load → 0x00000080.
- Half SEXT load at 0x102 with RAM word 0x8001_1234 → resp_data=0xFFFF8001. At 0x100 → 0x00001234.
- mem_not_ready held high for 3 cycles with req_valid=1: req_ready=0 and mem_en=0 throughout; issue occurs on the first cycle not_ready drops.
- Load with mem_read_valid withheld: fault pulses after 8 cycles with no resp_valid. Reset low while in RD_WAIT → IDLE, no response.
- With LSU_MISALIGN_TRAP_EN, word load at 0x101 → mem_en stays 0, fault=1 at +1. Without the macro → mem_addr=0x100, normal response.
